// File: rtl/window_frame_ctrl_if.sv
// Upstream/downstream beat handshake for the windowing sequencer.
// slave is the sequencer's view; master is the upstream/downstream side driving beats.
interface window_frame_ctrl_if;
  logic S_AXIS_TVALID;
  logic S_AXIS_TLAST;
  logic M_AXIS_TVALID;
  logic M_AXIS_TLAST;

  modport master (
    output S_AXIS_TVALID,
    output S_AXIS_TLAST,
    input  M_AXIS_TVALID,
    input  M_AXIS_TLAST
  );

  modport slave (
    input  S_AXIS_TVALID,
    input  S_AXIS_TLAST,
    output M_AXIS_TVALID,
    output M_AXIS_TLAST
  );
endinterface

// File: rtl/window_frame_ctrl.sv
// Frame sequencer for the windowing datapath: coefficient addressing, ping-pong bank swap at frame ends.
// Output valid/last trail each accepted beat by DELAY cycles; upstream is never stalled.
module window_frame_ctrl #(
  parameter int ADDR_W = 11,
  parameter int DELAY  = 3,
  parameter int CNT_W  = 16
) (
  input  logic              S_AXIS_ACLK,
  input  logic              S_AXIS_ARESETN,
  input  logic              cfg_enable,
  input  logic [ADDR_W:0]   cfg_frame_len,
  input  logic              cfg_bank_sel,
  input  logic              err_clr,
  window_frame_ctrl_if.slave axis,
  output logic [ADDR_W:0]   coef_addr,
  output logic              coef_bank,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic              err_early_last,
  output logic              err_late_last,
  output logic              busy
);
  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE     = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] idx_q;
  logic [ADDR_W:0]   len_q;
  logic              bank_q;
  logic [CNT_W-1:0]  frame_cnt_q;
  logic              err_early_q;
  logic              err_late_q;
  logic [DELAY-1:0]  vld_sr_q;
  logic [DELAY-1:0]  last_sr_q;

  logic [ADDR_W:0]   len_d;
  logic              active;
  logic              beat;
  logic              at_end;
  logic              frame_end;
  logic              early;
  logic              late;

  // Zero and oversize lengths both mean a full bank.
  always_comb begin
    len_d = cfg_frame_len;
    if (cfg_frame_len == '0 || cfg_frame_len > MAX_LEN) begin
      len_d = MAX_LEN;
    end
  end

  assign active    = (state_q != IDLE);
  assign beat      = active & axis.S_AXIS_TVALID;
  assign at_end    = ({1'b0, idx_q} == (len_q - ONE));
  assign frame_end = beat & (at_end | axis.S_AXIS_TLAST);
  assign early     = beat & axis.S_AXIS_TLAST & ~at_end;
  assign late      = beat & at_end & ~axis.S_AXIS_TLAST;

  always_ff @(posedge S_AXIS_ACLK) begin
    if (!S_AXIS_ARESETN) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      len_q       <= '0;
      bank_q      <= 1'b0;
      frame_cnt_q <= '0;
      err_early_q <= 1'b0;
      err_late_q  <= 1'b0;
      vld_sr_q    <= '0;
      last_sr_q   <= '0;
    end else begin
      vld_sr_q[0]  <= beat;
      last_sr_q[0] <= frame_end;
      for (int i = 1; i < DELAY; i++) begin
        vld_sr_q[i]  <= vld_sr_q[i-1];
        last_sr_q[i] <= last_sr_q[i-1];
      end

      // A fresh error wins over a simultaneous clear.
      err_early_q <= (err_early_q & ~err_clr) | early;
      err_late_q  <= (err_late_q & ~err_clr) | late;

      if (beat) begin
        idx_q <= frame_end ? '0 : idx_q + ADDR_W'(1);
      end

      if (frame_end) begin
        frame_cnt_q <= frame_cnt_q + CNT_W'(1);
        len_q       <= len_d;
        bank_q      <= cfg_bank_sel;
      end

      case (state_q)
        IDLE: begin
          idx_q <= '0;
          if (cfg_enable) begin
            len_q   <= len_d;
            bank_q  <= cfg_bank_sel;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (!cfg_enable) begin
            state_q <= frame_end ? IDLE : DRAIN;
          end
        end
        DRAIN: begin
          if (cfg_enable) begin
            state_q <= RUN;
          end else if (frame_end) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign coef_addr          = {bank_q, idx_q};
  assign coef_bank          = bank_q;
  assign frame_cnt          = frame_cnt_q;
  assign err_early_last     = err_early_q;
  assign err_late_last      = err_late_q;
  assign busy               = active;
  assign axis.M_AXIS_TVALID = vld_sr_q[DELAY-1];
  assign axis.M_AXIS_TLAST  = last_sr_q[DELAY-1];
endmodule

// File: tb/tb_window_frame_ctrl.sv
// Directed bench for window_frame_ctrl: output beats scored from a queue, status checked inline.
module tb_window_frame_ctrl;
  localparam int ADDR_W = 11;
  localparam int DELAY  = 3;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cfg_enable = 1'b0;
  logic [ADDR_W:0]   cfg_frame_len = '0;
  logic              cfg_bank_sel = 1'b0;
  logic              err_clr = 1'b0;
  logic [ADDR_W:0]   coef_addr;
  logic              coef_bank;
  logic [CNT_W-1:0]  frame_cnt;
  logic              err_early_last;
  logic              err_late_last;
  logic              busy;

  window_frame_ctrl_if axis ();

  window_frame_ctrl #(.ADDR_W(ADDR_W), .DELAY(DELAY), .CNT_W(CNT_W)) dut (
    .S_AXIS_ACLK    (clk),
    .S_AXIS_ARESETN (rst_n),
    .cfg_enable     (cfg_enable),
    .cfg_frame_len  (cfg_frame_len),
    .cfg_bank_sel   (cfg_bank_sel),
    .err_clr        (err_clr),
    .axis           (axis),
    .coef_addr      (coef_addr),
    .coef_bank      (coef_bank),
    .frame_cnt      (frame_cnt),
    .err_early_last (err_early_last),
    .err_late_last  (err_late_last),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   due;
    logic last;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h cycle=%0d", nm, act, exp, cyc);
    end
  endtask

  // Output monitor: every emitted beat must match the head of the queue in cycle and last.
  always @(negedge clk) begin
    if (rst_n) begin
      if (axis.M_AXIS_TVALID) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_unexpected actual tvalid=1 expected tvalid=0 cycle=%0d", cyc);
        end else begin
          mon_e = sbq.pop_front();
          chk("out_cycle", 32'(cyc), 32'(mon_e.due));
          chk("out_last", 32'(axis.M_AXIS_TLAST), 32'(mon_e.last));
        end
      end else if (sbq.size() != 0 && sbq[0].due < cyc) begin
        mon_e = sbq.pop_front();
        checks++;
        errors++;
        $display("FAIL out_missing actual tvalid=0 expected beat due at cycle %0d, now %0d", mon_e.due, cyc);
      end
    end
  end

  // Caller sits at a negedge; one beat is presented for the following posedge.
  task automatic beat(input logic tl, input logic [ADDR_W:0] exp_addr,
                      input logic exp_last, input logic exp_out);
    exp_t e;
    axis.S_AXIS_TVALID = 1'b1;
    axis.S_AXIS_TLAST  = tl;
    if (exp_out) begin
      chk("coef_addr", 32'(coef_addr), 32'(exp_addr));
      e.due  = cyc + DELAY;
      e.last = exp_last;
      sbq.push_back(e);
    end
    @(negedge clk);
    axis.S_AXIS_TVALID = 1'b0;
    axis.S_AXIS_TLAST  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start(input logic [ADDR_W:0] len, input logic bank);
    cfg_enable    = 1'b1;
    cfg_frame_len = len;
    cfg_bank_sel  = bank;
    @(negedge clk);
    chk("busy_run", 32'(busy), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    axis.S_AXIS_TVALID = 1'b0;
    axis.S_AXIS_TLAST  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_addr", 32'(coef_addr), 32'd0);
    chk("rst_bank", 32'(coef_bank), 32'd0);
    chk("rst_tvalid", 32'(axis.M_AXIS_TVALID), 32'd0);
    chk("rst_tlast", 32'(axis.M_AXIS_TLAST), 32'd0);
    chk("rst_fcnt", 32'(frame_cnt), 32'd0);
    chk("rst_errs", 32'({err_early_last, err_late_last}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    idle(2);

    // Two well-formed len-8 frames.
    start(12'd8, 1'b0);
    for (int i = 0; i < 16; i++) beat(i % 8 == 7, 12'(i % 8), i % 8 == 7, 1'b1);
    idle(DELAY + 2);
    chk("t1_fcnt", 32'(frame_cnt), 32'd2);
    chk("t1_errs", 32'({err_early_last, err_late_last}), 32'd0);

    // Bank request mid-frame only takes effect at the frame boundary.
    for (int i = 0; i < 16; i++) begin
      if (i == 3) cfg_bank_sel = 1'b1;
      if (i == 8) cfg_bank_sel = 1'b0;
      if (i == 7) chk("t2_bank_hold", 32'(coef_bank), 32'd0);
      if (i == 8) chk("t2_bank_swap", 32'(coef_bank), 32'd1);
      beat(i % 8 == 7, (i < 8) ? 12'(i) : (12'h800 | 12'(i - 8)), i % 8 == 7, 1'b1);
    end
    idle(DELAY + 2);
    chk("t2_fcnt", 32'(frame_cnt), 32'd4);
    chk("t2_bank_back", 32'(coef_bank), 32'd0);

    // Early TLAST on beat 4 ends the frame there.
    for (int i = 0; i < 5; i++) beat(i == 4, 12'(i), i == 4, 1'b1);
    chk("t3_wrap_addr", 32'(coef_addr), 32'd0);
    chk("t3_early", 32'(err_early_last), 32'd1);
    chk("t3_late", 32'(err_late_last), 32'd0);
    for (int i = 0; i < 8; i++) beat(i == 7, 12'(i), i == 7, 1'b1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("t3_clr", 32'(err_early_last), 32'd0);
    chk("t3_fcnt", 32'(frame_cnt), 32'd6);

    // Missing TLAST: frame still closes at index 7.
    for (int i = 0; i < 8; i++) beat(1'b0, 12'(i), i == 7, 1'b1);
    chk("t4_late", 32'(err_late_last), 32'd1);
    chk("t4_early0", 32'(err_early_last), 32'd0);
    chk("t4_fcnt", 32'(frame_cnt), 32'd7);
    // Stray TLAST at index 0 is early; clear in the same cycle must not mask it.
    cfg_frame_len = 12'd1;
    err_clr = 1'b1;
    beat(1'b1, 12'd0, 1'b1, 1'b1);
    err_clr = 1'b0;
    chk("t4_stray_early", 32'(err_early_last), 32'd1);
    chk("t4_late_clr", 32'(err_late_last), 32'd0);
    chk("t4_fcnt2", 32'(frame_cnt), 32'd8);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("t4_clr_both", 32'({err_early_last, err_late_last}), 32'd0);
    // len==1: every beat closes a frame.
    for (int i = 0; i < 3; i++) begin
      if (i == 2) cfg_frame_len = 12'd8;
      beat(1'b1, 12'd0, 1'b1, 1'b1);
    end
    chk("t4_len1_fcnt", 32'(frame_cnt), 32'd11);
    chk("t4_len1_errs", 32'({err_early_last, err_late_last}), 32'd0);

    // Disable mid-frame: finish the frame, then go idle and ignore beats.
    for (int i = 0; i < 8; i++) begin
      if (i == 2) cfg_enable = 1'b0;
      if (i == 5) chk("t5_busy_drain", 32'(busy), 32'd1);
      beat(i == 7, 12'(i), i == 7, 1'b1);
    end
    chk("t5_idle", 32'(busy), 32'd0);
    chk("t5_fcnt", 32'(frame_cnt), 32'd12);
    for (int i = 0; i < 3; i++) beat(1'b0, 12'd0, 1'b0, 1'b0);
    idle(DELAY + 2);
    chk("t5_sb_empty", 32'(sbq.size()), 32'd0);

    // Zero length means a full 2048-entry bank.
    start(12'd0, 1'b0);
    for (int i = 0; i < 2048; i++) beat(i == 2047, 12'(i), i == 2047, 1'b1);
    idle(DELAY + 2);
    chk("t6_fcnt", 32'(frame_cnt), 32'd13);
    chk("t6_errs", 32'({err_early_last, err_late_last}), 32'd0);

    // Reset with beats in flight drops them.
    beat(1'b0, 12'd0, 1'b0, 1'b0);
    beat(1'b0, 12'd1, 1'b0, 1'b0);
    rst_n = 1'b0;
    cfg_enable = 1'b0;
    @(negedge clk);
    chk("t6_rst_tvalid", 32'(axis.M_AXIS_TVALID), 32'd0);
    chk("t6_rst_fcnt", 32'(frame_cnt), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_addr", 32'(coef_addr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(DELAY + 3);
    chk("t6_post_tvalid", 32'(axis.M_AXIS_TVALID), 32'd0);
    chk("final_sb_empty", 32'(sbq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
